// File: rtl/cache_tag_ctrl_if.sv
// Request/response and tag-store bundle for the cache tag controller.
// master: requester plus tag store side; slave: the controller.
// Widths follow the WIDTH/WAYS/TOTAL_SIZE parameters of the controller.
interface cache_tag_ctrl_if #(
  parameter int WIDTH      = 8,
  parameter int WAYS       = 4,
  parameter int TOTAL_SIZE = 16
);
  localparam int SETS  = TOTAL_SIZE / WAYS;
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_index;
  logic [WIDTH-1:0] req_tag;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_hit;
  logic [WAY_W-1:0] resp_way;
  logic             resp_evict;
  logic [WIDTH-1:0] resp_evict_tag;
  logic             tag_we;
  logic [WAY_W-1:0] tag_way;
  logic [IDX_W-1:0] tag_index;
  logic [WIDTH-1:0] tag_wdata;
  logic [WIDTH-1:0] tag_rdata [0:WAYS-1];

  modport master (
    output req_valid, req_index, req_tag, flush, resp_ready, tag_rdata,
    input  req_ready, resp_valid, resp_hit, resp_way, resp_evict, resp_evict_tag,
    input  tag_we, tag_way, tag_index, tag_wdata
  );

  modport slave (
    input  req_valid, req_index, req_tag, flush, resp_ready, tag_rdata,
    output req_ready, resp_valid, resp_hit, resp_way, resp_evict, resp_evict_tag,
    output tag_we, tag_way, tag_index, tag_wdata
  );
endinterface

// File: rtl/cache_tag_ctrl.sv
// Set-associative tag lookup/replacement controller with per-line valid bits.
// Latency: response 2 cycles after request (hit), 3 cycles (miss with fill).
// Backpressure: one request in flight; response held until resp_ready, req_ready low meanwhile.
module cache_tag_ctrl #(
  parameter int WIDTH      = 8,
  parameter int WAYS       = 4,
  parameter int TOTAL_SIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  cache_tag_ctrl_if.slave  bus
);
  localparam int SETS  = TOTAL_SIZE / WAYS;
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] tag_q;
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAY_W-1:0] rr_q    [SETS];

  logic             resp_valid_q;
  logic             resp_hit_q;
  logic [WAY_W-1:0] resp_way_q;
  logic             resp_evict_q;
  logic [WIDTH-1:0] resp_evict_tag_q;
  logic             tag_we_q;
  logic [WAY_W-1:0] tag_way_q;
  logic [WIDTH-1:0] tag_wdata_q;

  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic             inv_any;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] victim;

  // Tag compare across all ways of the latched set; lowest matching / lowest free way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_any && valid_q[idx_q][w] && (bus.tag_rdata[w] == tag_q)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_any && !valid_q[idx_q][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    victim = inv_any ? inv_way : rr_q[idx_q];
  end

  // Controller FSM with registered response and tag-store write outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      tag_q            <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      resp_valid_q     <= 1'b0;
      resp_hit_q       <= 1'b0;
      resp_way_q       <= '0;
      resp_evict_q     <= 1'b0;
      resp_evict_tag_q <= '0;
      tag_we_q         <= 1'b0;
      tag_way_q        <= '0;
      tag_wdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.flush) begin
            // Flush beats a same-cycle request; that request is simply not accepted.
            for (int s = 0; s < SETS; s++) begin
              valid_q[s] <= '0;
              rr_q[s]    <= '0;
            end
          end else if (bus.req_valid) begin
            idx_q   <= bus.req_index;
            tag_q   <= bus.req_tag;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          resp_hit_q <= hit_any;
          if (hit_any) begin
            resp_way_q       <= hit_way;
            resp_evict_q     <= 1'b0;
            resp_evict_tag_q <= '0;
            resp_valid_q     <= 1'b1;
            state_q          <= RESP;
          end else begin
            resp_way_q       <= victim;
            resp_evict_q     <= valid_q[idx_q][victim];
            resp_evict_tag_q <= valid_q[idx_q][victim] ? bus.tag_rdata[victim] : '0;
            tag_we_q         <= 1'b1;
            tag_way_q        <= victim;
            tag_wdata_q      <= tag_q;
            state_q          <= FILL;
          end
        end
        FILL: begin
          valid_q[idx_q][tag_way_q] <= 1'b1;
          rr_q[idx_q]               <= tag_way_q + WAY_W'(1);
          tag_we_q                  <= 1'b0;
          tag_way_q                 <= '0;
          tag_wdata_q               <= '0;
          resp_valid_q              <= 1'b1;
          state_q                   <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q     <= 1'b0;
            resp_hit_q       <= 1'b0;
            resp_way_q       <= '0;
            resp_evict_q     <= 1'b0;
            resp_evict_tag_q <= '0;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = (state_q == IDLE) && !bus.flush;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_hit       = resp_hit_q;
  assign bus.resp_way       = resp_way_q;
  assign bus.resp_evict     = resp_evict_q;
  assign bus.resp_evict_tag = resp_evict_tag_q;
  assign bus.tag_we         = tag_we_q;
  assign bus.tag_way        = tag_way_q;
  assign bus.tag_index      = idx_q;
  assign bus.tag_wdata      = tag_wdata_q;
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Testbench for cache_tag_ctrl: directed scenarios then random lookups vs a set/way model.
// Latency is counted in clock edges from the edge that accepts the request.
// Tag store is a plain array written on tag_we and read combinationally.
module tb_cache_tag_ctrl;
  localparam int WIDTH = 8;
  localparam int WAYS  = 4;
  localparam int SETS  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  cache_tag_ctrl_if #(.WIDTH(WIDTH), .WAYS(WAYS), .TOTAL_SIZE(16)) bus ();

  cache_tag_ctrl #(.WIDTH(WIDTH), .WAYS(WAYS), .TOTAL_SIZE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Tag store
  logic [WIDTH-1:0] store [SETS][WAYS];
  always @(posedge clk) if (bus.tag_we) store[bus.tag_index][bus.tag_way] <= bus.tag_wdata;
  always_comb begin
    for (int w = 0; w < WAYS; w++) bus.tag_rdata[w] = store[bus.tag_index][w];
  end

  // Reference model: which tag each line holds, whether it is live, next victim per set
  bit              m_vld [SETS][WAYS];
  logic [WIDTH-1:0] m_tag [SETS][WAYS];
  int              m_rr  [SETS];

  bit              e_hit;
  int              e_way;
  bit              e_evict;
  logic [WIDTH-1:0] e_evtag;

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_vld[s][w] = 0;
    end
  endtask

  task automatic model_access(input int idx, input logic [WIDTH-1:0] t);
    int victim;
    e_hit = 0; e_way = 0; e_evict = 0; e_evtag = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (m_vld[idx][w] && m_tag[idx][w] == t) begin e_hit = 1; e_way = w; end
    if (!e_hit) begin
      victim = -1;
      for (int w = WAYS - 1; w >= 0; w--) if (!m_vld[idx][w]) victim = w;
      if (victim < 0) victim = m_rr[idx];
      e_way   = victim;
      e_evict = m_vld[idx][victim];
      e_evtag = e_evict ? m_tag[idx][victim] : '0;
      m_vld[idx][victim] = 1;
      m_tag[idx][victim] = t;
      m_rr[idx] = (victim + 1) % WAYS;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // One request; hold_cycles keeps resp_ready low that many cycles after the response appears.
  task automatic do_req(input int idx, input logic [WIDTH-1:0] t, input int hold_cycles);
    int cyc;
    int we_cnt;
    bit hold_hit;
    int hold_way;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_index  = 2'(idx);
    bus.req_tag    = t;
    bus.flush      = 1'b0;
    bus.resp_ready = (hold_cycles == 0);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    model_access(idx, t);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc = 1;
    we_cnt = 0;
    while (!bus.resp_valid && cyc < 10) begin
      if (bus.tag_we) begin
        we_cnt++;
        chk("fill_way", 32'(bus.tag_way), 32'(e_way));
        chk("fill_index", 32'(bus.tag_index), 32'(idx));
        chk("fill_wdata", 32'(bus.tag_wdata), 32'(t));
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("latency", 32'(cyc), e_hit ? 32'd2 : 32'd3);
    chk("tag_we_count", 32'(we_cnt), e_hit ? 32'd0 : 32'd1);
    chk("resp_hit", 32'(bus.resp_hit), 32'(e_hit));
    chk("resp_way", 32'(bus.resp_way), 32'(e_way));
    chk("resp_evict", 32'(bus.resp_evict), 32'(e_evict));
    chk("resp_evict_tag", 32'(bus.resp_evict_tag), 32'(e_evtag));
    chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    hold_hit = bus.resp_hit;
    hold_way = 32'(bus.resp_way);
    for (int h = 0; h < hold_cycles; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_hit", 32'(bus.resp_hit), 32'(hold_hit));
      chk("hold_way", 32'(bus.resp_way), 32'(hold_way));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("resp_drop", 32'(bus.resp_valid), 32'd0);
    chk("back_idle", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_index  = '0;
    bus.req_tag    = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_tag_we", 32'(bus.tag_we), 32'd0);
    chk("rst_tag_index", 32'(bus.tag_index), 32'd0);
    chk("rst_resp_evict", 32'(bus.resp_evict), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss, then hit on the same line
    do_req(2, 8'h00, 0);
    do_req(2, 8'h00, 0);

    // Fill set 1 then two round-robin replacements
    for (int i = 0; i < 6; i++) do_req(1, 8'(8'h10 + i), 0);

    // Response backpressure
    do_req(1, 8'h15, 5);

    // Flush together with a request: request must be dropped
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_index = 2'd3;
    bus.req_tag   = 8'hAA;
    #1;
    chk("flush_blocks_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    model_clear();
    repeat (3) begin
      @(posedge clk); #1;
      chk("flush_no_resp", 32'(bus.resp_valid), 32'd0);
      chk("flush_no_we", 32'(bus.tag_we), 32'd0);
    end
    do_req(1, 8'h14, 0);

    // Reset while filling
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_index = 2'd0;
    bus.req_tag   = 8'h5A;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_fill_we", 32'(bus.tag_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_fill_we", 32'(bus.tag_we), 32'd0);
    chk("rst_fill_way", 32'(bus.tag_way), 32'd0);
    chk("rst_fill_index", 32'(bus.tag_index), 32'd0);
    chk("rst_fill_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    do_req(1, 8'h14, 0);
    do_req(0, 8'h5A, 0);

    // Random traffic with occasional flushes
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        model_clear();
      end
      do_req(int'($urandom_range(0, SETS - 1)), 8'($urandom_range(0, 9)),
             ($urandom_range(0, 7) == 0) ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
